// File: rtl/bus_cycle_ctl.sv
// bus_cycle_ctl: Z80 machine-cycle sequencer (M1, mem rd/wr, io rd/wr), one T-state per clock.
module bus_cycle_ctl #(
  parameter int IO_WAIT = 1
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [2:0]  cycle_type,
  input  logic [15:0] address,
  input  logic [15:0] rfsh_addr,
  input  logic [7:0]  wr_data,
  input  logic        nWAIT,
  input  logic [7:0]  D_in,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        d_oe,
  output logic        nM1,
  output logic        nMREQ,
  output logic        nIORQ,
  output logic        nRD,
  output logic        nWR,
  output logic        nRFSH,
  output logic [7:0]  rd_data,
  output logic        ready,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4} state_t;
  localparam logic [2:0] M1 = 3'd0, MEM_RD = 3'd1, MEM_WR = 3'd2, IO_RD = 3'd3, IO_WR = 3'd4;
  state_t      r_state, w_next;
  logic [2:0]  r_type, w_type;
  logic [15:0] r_addr, r_rfsh, w_addr, w_rfsh, w_a;
  logic [7:0]  r_wdata, w_wdata;
  logic [1:0]  r_wcnt, w_wcnt;
  logic        w_accept, w_io, w_act, w_late, w_t3, w_t4, w_capture;
  logic        w_nm1, w_nmreq, w_niorq, w_nrd, w_nwr, w_nrfsh, w_oe, w_done;
  always_comb begin
    w_accept = start && ready && (cycle_type <= IO_WR);
    w_type   = w_accept ? cycle_type : r_type;
    w_addr   = w_accept ? address : r_addr;
    w_rfsh   = w_accept ? rfsh_addr : r_rfsh;
    w_wdata  = w_accept ? wr_data : r_wdata;
    w_wcnt   = r_wcnt;
    w_next   = r_state;
    case (r_state)
      IDLE: w_next = w_accept ? T1 : IDLE;
      T1:   w_next = T2;
      T2: begin
        // I/O cycles first burn the automatic waits, ignoring nWAIT meanwhile
        if ((r_type == IO_RD || r_type == IO_WR) && IO_WAIT > 0) begin
          w_next = TW;
          w_wcnt = 2'(IO_WAIT - 1);
        end else
          w_next = nWAIT ? T3 : TW;
      end
      TW: begin
        if (r_wcnt != 2'd0)
          w_wcnt = r_wcnt - 2'd1;
        else
          w_next = nWAIT ? T3 : TW;
      end
      T3:      w_next = (r_type == M1) ? T4 : (w_accept ? T1 : IDLE);
      T4:      w_next = w_accept ? T1 : IDLE;
      default: w_next = IDLE;
    endcase
    w_capture = (r_state == T2 || r_state == TW) && w_next == T3 && r_type != MEM_WR && r_type != IO_WR;
    w_io    = w_type == IO_RD || w_type == IO_WR;
    w_act   = w_next == T1 || w_next == T2 || w_next == TW;
    w_late  = w_next == T2 || w_next == TW || w_next == T3;
    w_t3    = w_next == T3;
    w_t4    = w_next == T4;
    w_nm1   = !(w_type == M1 && w_act);
    w_nmreq = !(w_type <= MEM_WR && (w_act || w_t3));
    w_niorq = !(w_io && w_late);
    w_nrd   = !((w_type == M1 && w_act) || (w_type == MEM_RD && (w_act || w_t3)) || (w_type == IO_RD && w_late));
    w_nwr   = !((w_type == MEM_WR || w_type == IO_WR) && w_late);
    w_nrfsh = !(w_type == M1 && (w_t3 || w_t4));
    w_oe    = (w_type == MEM_WR && (w_act || w_t3)) || (w_type == IO_WR && w_late);
    w_done  = (w_t3 && w_type != M1) || w_t4;
    w_a     = (w_next == IDLE) ? A : ((w_type == M1 && (w_t3 || w_t4)) ? w_rfsh : w_addr);
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state <= IDLE;
      r_type  <= M1;
      r_addr  <= '0;
      r_rfsh  <= '0;
      r_wdata <= '0;
      r_wcnt  <= '0;
      A       <= '0;
      D_out   <= '0;
      d_oe    <= 1'b0;
      nM1     <= 1'b1;
      nMREQ   <= 1'b1;
      nIORQ   <= 1'b1;
      nRD     <= 1'b1;
      nWR     <= 1'b1;
      nRFSH   <= 1'b1;
      rd_data <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_type  <= w_type;
      r_addr  <= w_addr;
      r_rfsh  <= w_rfsh;
      r_wdata <= w_wdata;
      r_wcnt  <= w_wcnt;
      A       <= w_a;
      D_out   <= w_oe ? w_wdata : D_out;
      d_oe    <= w_oe;
      nM1     <= w_nm1;
      nMREQ   <= w_nmreq;
      nIORQ   <= w_niorq;
      nRD     <= w_nrd;
      nWR     <= w_nwr;
      nRFSH   <= w_nrfsh;
      rd_data <= w_capture ? D_in : rd_data;
      ready   <= w_next == IDLE || w_done;
      done    <= w_done;
    end
  end
endmodule

// File: tb/tb_bus_cycle_ctl.sv
// tb_bus_cycle_ctl: scoreboard bench; per-clock expected bus state is queued at issue time and compared on negedges.
module tb_bus_cycle_ctl;
  localparam int IOW = 1;
  logic        clk = 1'b0, nreset = 1'b0, start = 1'b0, nWAIT = 1'b1;
  logic [2:0]  cycle_type = '0;
  logic [15:0] address = '0, rfsh_addr = '0;
  logic [7:0]  wr_data = '0, D_in = '0;
  logic [15:0] A;
  logic [7:0]  D_out, rd_data;
  logic        d_oe, nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, ready, done;
  int checks = 0, failures = 0;
  logic [15:0] model_a = '0;
  logic [7:0]  model_rd = '0;
  typedef struct packed {
    logic [15:0] a;
    logic [5:0]  stb;
    logic        oe;
    logic        dn;
    logic        rdy;
  } out_t;
  typedef struct {
    out_t        e;
    logic [7:0]  erd, edout;
    int          st;
    logic        nw;
    logic [7:0]  din;
    logic        go;
    logic [2:0]  ty;
    logic [15:0] ad, rf;
    logic [7:0]  wd;
  } ent_t;
  ent_t q[$];

  bus_cycle_ctl #(.IO_WAIT(IOW)) dut (
    .clk(clk), .nreset(nreset), .start(start), .cycle_type(cycle_type),
    .address(address), .rfsh_addr(rfsh_addr), .wr_data(wr_data), .nWAIT(nWAIT),
    .D_in(D_in), .A(A), .D_out(D_out), .d_oe(d_oe), .nM1(nM1), .nMREQ(nMREQ),
    .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH), .rd_data(rd_data),
    .ready(ready), .done(done)
  );

  always #5 clk = ~clk;

  // strobe vector order: {nM1,nMREQ,nIORQ,nRD,nWR,nRFSH}; st: 0 idle,1 T1,2 T2,3 TW,4 T3,5 T4
  function automatic out_t expo(input logic [2:0] ty, input int st, input logic [15:0] a, input logic [15:0] r);
    out_t o;
    o.a = a; o.stb = 6'b111111; o.oe = 1'b0; o.dn = 1'b0; o.rdy = (st == 0);
    if (st == 0) return o;
    case (ty)
      3'd0: begin
        if (st <= 3) o.stb = 6'b001011;
        else if (st == 4) begin o.a = r; o.stb = 6'b101110; end
        else begin o.a = r; o.stb = 6'b111110; o.dn = 1'b1; end
      end
      3'd1: begin o.stb = 6'b101011; o.dn = (st == 4); end
      3'd2: begin o.oe = 1'b1; o.stb = (st >= 2) ? 6'b101101 : 6'b101111; o.dn = (st == 4); end
      3'd3: begin if (st >= 2) o.stb = 6'b110011; o.dn = (st == 4); end
      default: begin if (st >= 2) begin o.stb = 6'b110101; o.oe = 1'b1; end o.dn = (st == 4); end
    endcase
    o.rdy = o.dn;
    return o;
  endfunction

  task automatic push_idle(input logic go, input logic [2:0] ty);
    ent_t x;
    x.e = expo(ty, 0, model_a, 16'h0); x.erd = model_rd; x.edout = 8'h00; x.st = 0; x.nw = 1'b1;
    x.din = 8'($urandom); x.go = go; x.ty = ty; x.ad = 16'($urandom); x.rf = 16'($urandom); x.wd = 8'($urandom);
    q.push_back(x);
  endtask

  task automatic issue(input logic [2:0] ty, input logic [15:0] a, input logic [15:0] r, input logic [7:0] wd,
                       input logic [7:0] din, input int waits, input bit b2b);
    int aw, n, last;
    int sts[$];
    ent_t x;
    aw = (ty == 3'd3 || ty == 3'd4) ? IOW : 0;
    if (b2b) begin
      q[q.size()-1].go = 1'b1; q[q.size()-1].ty = ty; q[q.size()-1].ad = a;
      q[q.size()-1].rf = r; q[q.size()-1].wd = wd;
    end else begin
      push_idle(1'b0, 3'd0);
      q[q.size()-1].go = 1'b1; q[q.size()-1].ty = ty; q[q.size()-1].ad = a;
      q[q.size()-1].rf = r; q[q.size()-1].wd = wd;
    end
    sts.push_back(1); sts.push_back(2);
    for (int i = 0; i < aw + waits; i++) sts.push_back(3);
    sts.push_back(4);
    if (ty == 3'd0) sts.push_back(5);
    n = sts.size();
    last = 1 + aw + waits;
    for (int i = 0; i < n; i++) begin
      x.st = sts[i];
      x.e = expo(ty, sts[i], a, r);
      if (i == 2 + aw + waits && ty != 3'd2 && ty != 3'd4) model_rd = din;
      x.erd = model_rd;
      x.edout = wd;
      x.nw = (i + 1 <= 1 + aw) ? 1'b1 : ((i + 1 <= last) ? 1'b0 : 1'b1);
      x.din = (i == last) ? din : 8'($urandom);
      x.go = 1'b0; x.ty = 3'($urandom_range(0, 7)); x.ad = 16'($urandom); x.rf = 16'($urandom); x.wd = 8'($urandom);
      q.push_back(x);
    end
    model_a = (ty == 3'd0) ? r : a;
  endtask

  task automatic drain();
    ent_t x;
    out_t got;
    while (q.size() > 0) begin
      x = q.pop_front();
      @(negedge clk);
      got = '{a: A, stb: {nM1, nMREQ, nIORQ, nRD, nWR, nRFSH}, oe: d_oe, dn: done, rdy: ready};
      checks++;
      if (got.a !== x.e.a) begin failures++; $display("FAIL addr st=%0d got=%h exp=%h", x.st, got.a, x.e.a); end
      checks++;
      if (got.stb !== x.e.stb) begin failures++; $display("FAIL strobes st=%0d got=%b exp=%b", x.st, got.stb, x.e.stb); end
      checks++;
      if (got.oe !== x.e.oe || got.dn !== x.e.dn || got.rdy !== x.e.rdy)
        begin failures++; $display("FAIL oe_done_ready st=%0d got=%b%b%b exp=%b%b%b", x.st, got.oe, got.dn, got.rdy, x.e.oe, x.e.dn, x.e.rdy); end
      checks++;
      if (rd_data !== x.erd) begin failures++; $display("FAIL rd_data st=%0d got=%h exp=%h", x.st, rd_data, x.erd); end
      if (x.e.oe) begin
        checks++;
        if (D_out !== x.edout) begin failures++; $display("FAIL d_out st=%0d got=%h exp=%h", x.st, D_out, x.edout); end
      end
      start = x.go; cycle_type = x.ty; address = x.ad; rfsh_addr = x.rf; wr_data = x.wd;
      nWAIT = x.nw; D_in = x.din;
    end
    start = 1'b0;
  endtask

  task automatic check_idle_pins(input string nm, input logic [15:0] ea);
    checks++;
    if ({nM1, nMREQ, nIORQ, nRD, nWR, nRFSH} !== 6'b111111 || d_oe !== 1'b0 || done !== 1'b0 || ready !== 1'b1 || A !== ea)
      begin failures++; $display("FAIL %s got stb=%b oe=%b done=%b rdy=%b A=%h exp stb=111111 oe=0 done=0 rdy=1 A=%h",
                                  nm, {nM1, nMREQ, nIORQ, nRD, nWR, nRFSH}, d_oe, done, ready, A, ea); end
  endtask

  task automatic test_reset();
    nreset = 1'b0; start = 1'b1; cycle_type = 3'd1;
    repeat (3) @(negedge clk);
    check_idle_pins("reset", 16'h0000);
    checks++;
    if (rd_data !== 8'h00 || D_out !== 8'h00) begin failures++; $display("FAIL reset_data got rd=%h dout=%h exp 00 00", rd_data, D_out); end
    start = 1'b0; nreset = 1'b1;
    model_a = '0; model_rd = '0;
  endtask

  task automatic test_mem_read();
    issue(3'd1, 16'h1234, 16'h0000, 8'h00, 8'h5A, 0, 1'b0);
    push_idle(1'b0, 3'd0); drain();
  endtask

  task automatic test_m1_fetch();
    issue(3'd0, 16'h0100, 16'h3F07, 8'h00, 8'hC3, 0, 1'b0);
    issue(3'd0, 16'h0200, 16'h3F08, 8'h00, 8'h77, 1, 1'b0);
    push_idle(1'b0, 3'd0); drain();
  endtask

  task automatic test_mem_write();
    issue(3'd2, 16'h8000, 16'h0000, 8'hA5, 8'h00, 2, 1'b0);
    push_idle(1'b0, 3'd0); drain();
  endtask

  task automatic test_io();
    issue(3'd3, 16'h00FE, 16'h0000, 8'h00, 8'h3C, 0, 1'b0);
    issue(3'd4, 16'h10FF, 16'h0000, 8'h81, 8'h00, 1, 1'b0);
    issue(3'd3, 16'h0055, 16'h0000, 8'h00, 8'hE1, 2, 1'b0);
    push_idle(1'b0, 3'd0); drain();
  endtask

  task automatic test_back_to_back();
    issue(3'd1, 16'h4000, 16'h0000, 8'h00, 8'h12, 0, 1'b0);
    issue(3'd2, 16'h4001, 16'h0000, 8'h99, 8'h00, 0, 1'b1);
    issue(3'd0, 16'h0300, 16'h1122, 8'h00, 8'h44, 0, 1'b1);
    issue(3'd4, 16'h0033, 16'h0000, 8'h5C, 8'h00, 0, 1'b1);
    push_idle(1'b0, 3'd0); drain();
  endtask

  task automatic test_reserved();
    push_idle(1'b1, 3'd5);
    push_idle(1'b1, 3'd6);
    push_idle(1'b0, 3'd0);
    push_idle(1'b0, 3'd0);
    drain();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; cycle_type = 3'd0; address = 16'h0ABC; rfsh_addr = 16'h2233; nWAIT = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (nM1 !== 1'b0 || ready !== 1'b0) begin failures++; $display("FAIL mid_in_tw got nM1=%b rdy=%b exp 0 0", nM1, ready); end
    nreset = 1'b0;
    @(negedge clk);
    check_idle_pins("reset_mid", 16'h0000);
    nreset = 1'b1; nWAIT = 1'b1; start = 1'b1; cycle_type = 3'd7; address = 16'hFFFF;
    @(negedge clk); start = 1'b0;
    check_idle_pins("reserved_after_reset", 16'h0000);
    @(negedge clk);
    check_idle_pins("reserved_after_reset2", 16'h0000);
    model_a = '0; model_rd = '0;
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_m1_fetch();
    test_mem_write();
    test_io();
    test_back_to_back();
    test_reserved();
    test_reset_mid();
    test_mem_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
